// File: rtl/exanet_arb_pkg.sv
// Shared types and sizing for the per-output VC arbiter of the switch.
// Flat VC index is v = p*VC_NUM + vc, so higher flat indices belong to higher priority levels.
package exanet_arb_pkg;

    localparam int VC_NUM   = 3;
    localparam int PRIO_NUM = 2;
    localparam int VC_TOT   = PRIO_NUM * VC_NUM;
    localparam int VC_W     = $clog2(VC_TOT);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    typedef logic [VC_W-1:0] vc_idx_t;

    function automatic vc_idx_t flat_vc(input int p, input int vc);
        return vc_idx_t'(p * VC_NUM + vc);
    endfunction

endpackage

// File: rtl/output_vc_arbiter_rr_picker.sv
// One-hot round-robin selector: the first set request at or after i_ptr, wrapping at N.
module rr_picker #(
    parameter int N = 8,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[(int'(i_ptr) + k) % N]) begin
                o_gnt[(int'(i_ptr) + k) % N] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_vc_arbiter.sv
// Per-output arbiter: credit-aware, priority-ordered, round-robin within a level.
// A grant is held from selection until the beat carrying last is accepted.
module output_vc_arbiter
    import exanet_arb_pkg::*;
#(
    parameter int vc_num      = VC_NUM,
    parameter int prio_num    = PRIO_NUM,
    parameter int input_num   = 8,
    parameter int max_credits = 8
) (
    input  logic                                            clk,
    input  logic                                            resetn,
    input  logic [input_num-1:0][prio_num*vc_num-1:0]       request,
    input  logic                                            beat_valid,
    input  logic                                            beat_last,
    input  logic                                            out_ready,
    input  logic [prio_num*vc_num-1:0]                      credit_return,
    output logic [input_num-1:0]                            grant,
    output logic [$clog2(prio_num*vc_num)-1:0]              grant_vc,
    output logic                                            beat_ready,
    output logic                                            credit_err,
    output logic                                            o_dbg_state
);

    localparam int VT = prio_num * vc_num;
    localparam int VW = $clog2(VT);
    localparam int CW = $clog2(max_credits + 1);
    localparam int IW = (input_num > 1) ? $clog2(input_num) : 1;
    localparam int PW = (prio_num > 1) ? $clog2(prio_num) : 1;
    localparam logic [CW-1:0] CMAX = CW'(max_credits);

    arb_state_t           r_state;
    logic [input_num-1:0] r_grant;
    logic [VW-1:0]        r_grant_vc;
    logic [IW-1:0]        r_gnt_idx;
    logic [PW-1:0]        r_gnt_prio;
    logic [IW-1:0]        r_rr_ptr [prio_num];
    logic [CW-1:0]        r_credit [VT];
    logic                 r_credit_err;

    logic [VT-1:0]        w_credit_ok;
    logic [VT-1:0]        w_dec;
    logic [input_num-1:0] w_level_req  [prio_num];
    logic [input_num-1:0] w_level_pick [prio_num];
    logic                 w_any;
    logic [PW-1:0]        w_sel_prio;
    logic [input_num-1:0] w_sel_onehot;
    logic [IW-1:0]        w_sel_idx;
    logic [VW-1:0]        w_sel_vc;
    logic                 w_beat_ready;
    logic                 w_accept;
    logic [IW-1:0]        w_next_ptr;

    always_comb begin
        for (int v = 0; v < VT; v++) begin
            w_credit_ok[v] = (r_credit[v] != '0);
        end
    end

    // An input competes in level p if it requests any VC of p that still has credit.
    always_comb begin
        for (int p = 0; p < prio_num; p++) begin
            w_level_req[p] = '0;
            for (int i = 0; i < input_num; i++) begin
                w_level_req[p][i] = |(request[i][p*vc_num +: vc_num] & w_credit_ok[p*vc_num +: vc_num]);
            end
        end
    end

    for (genvar p = 0; p < prio_num; p++) begin : g_level
        rr_picker #(.N(input_num)) u_pick (
            .i_req (w_level_req[p]),
            .i_ptr (r_rr_ptr[p]),
            .o_gnt (w_level_pick[p])
        );
    end

    always_comb begin
        w_any        = 1'b0;
        w_sel_prio   = '0;
        w_sel_onehot = '0;
        for (int p = 0; p < prio_num; p++) begin
            if (|w_level_req[p]) begin
                w_any        = 1'b1;
                w_sel_prio   = PW'(p);
                w_sel_onehot = w_level_pick[p];
            end
        end
        w_sel_idx = '0;
        for (int i = 0; i < input_num; i++) begin
            if (w_sel_onehot[i]) w_sel_idx = IW'(i);
        end
        w_sel_vc = '0;
        for (int vc = vc_num - 1; vc >= 0; vc--) begin
            if (request[w_sel_idx][int'(w_sel_prio)*vc_num + vc] &&
                w_credit_ok[int'(w_sel_prio)*vc_num + vc]) begin
                w_sel_vc = VW'(int'(w_sel_prio)*vc_num + vc);
            end
        end
    end

    assign w_beat_ready = (r_state == GRANTED) && out_ready && w_credit_ok[r_grant_vc];
    assign w_accept     = beat_valid && w_beat_ready;
    assign w_next_ptr   = (r_gnt_idx == IW'(input_num - 1)) ? '0 : r_gnt_idx + IW'(1);

    always_comb begin
        for (int v = 0; v < VT; v++) begin
            w_dec[v] = w_accept && (r_grant_vc == VW'(v));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_vc <= '0;
            r_gnt_idx  <= '0;
            r_gnt_prio <= '0;
            for (int p = 0; p < prio_num; p++) r_rr_ptr[p] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state    <= GRANTED;
                        r_grant    <= w_sel_onehot;
                        r_grant_vc <= w_sel_vc;
                        r_gnt_idx  <= w_sel_idx;
                        r_gnt_prio <= w_sel_prio;
                    end
                end
                GRANTED: begin
                    if (w_accept && beat_last) begin
                        r_state              <= IDLE;
                        r_grant              <= '0;
                        r_rr_ptr[r_gnt_prio] <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A return and a consume on the same VC cancel; a return into a full counter is an error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_credit_err <= 1'b0;
            for (int v = 0; v < VT; v++) r_credit[v] <= CMAX;
        end else begin
            for (int v = 0; v < VT; v++) begin
                if (credit_return[v] && !w_dec[v]) begin
                    if (r_credit[v] == CMAX) r_credit_err <= 1'b1;
                    else                     r_credit[v] <= r_credit[v] + CW'(1);
                end else if (!credit_return[v] && w_dec[v]) begin
                    r_credit[v] <= r_credit[v] - CW'(1);
                end
            end
        end
    end

    assign grant       = r_grant;
    assign grant_vc    = r_grant_vc;
    assign beat_ready  = w_beat_ready;
    assign credit_err  = r_credit_err;
    assign o_dbg_state = (r_state == GRANTED);

endmodule

// File: tb/tb_output_vc_arbiter.sv
// Directed bench for output_vc_arbiter: one task per scenario, hand-computed expectations.
module tb_output_vc_arbiter;
    import exanet_arb_pkg::*;

    logic            clk = 1'b0;
    logic            resetn;
    logic [7:0][5:0] request;
    logic            beat_valid;
    logic            beat_last;
    logic            out_ready;
    logic [5:0]      credit_return;
    logic [7:0]      grant;
    logic [2:0]      grant_vc;
    logic            beat_ready;
    logic            credit_err;
    logic            o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    output_vc_arbiter dut (
        .clk           (clk),
        .resetn        (resetn),
        .request       (request),
        .beat_valid    (beat_valid),
        .beat_last     (beat_last),
        .out_ready     (out_ready),
        .credit_return (credit_return),
        .grant         (grant),
        .grant_vc      (grant_vc),
        .beat_ready    (beat_ready),
        .credit_err    (credit_err),
        .o_dbg_state   (o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        request       = '0;
        beat_valid    = 1'b0;
        beat_last     = 1'b0;
        out_ready     = 1'b0;
        credit_return = '0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        apply_reset();
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL reset_grant: got %h expected %h", grant, 8'h00); end
        n_checks++; if (grant_vc !== 3'd0) begin n_fail++; $display("FAIL reset_grant_vc: got %0d expected 0", grant_vc); end
        n_checks++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL reset_beat_ready: got %b expected 0", beat_ready); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err: got %b expected 0", credit_err); end
        n_checks++; if (o_dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b expected 0", o_dbg_state); end
        for (int v = 0; v < 6; v++) begin
            n_checks++;
            if (dut.r_credit[v] !== 4'd8) begin n_fail++; $display("FAIL reset_credit[%0d]: got %0d expected 8", v, dut.r_credit[v]); end
        end
    endtask

    task automatic test_single;
        request[2][1] = 1'b1;
        tick();
        n_checks++; if (grant !== 8'h04) begin n_fail++; $display("FAIL single_grant: got %h expected %h", grant, 8'h04); end
        n_checks++; if (grant_vc !== flat_vc(0, 1)) begin n_fail++; $display("FAIL single_grant_vc: got %0d expected 1", grant_vc); end
        request    = '0;
        beat_valid = 1'b1;
        out_ready  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            beat_last = (b == 2);
            #1;
            n_checks++; if (beat_ready !== 1'b1) begin n_fail++; $display("FAIL single_beat_ready[%0d]: got %b expected 1", b, beat_ready); end
            n_checks++; if (grant !== 8'h04) begin n_fail++; $display("FAIL single_hold[%0d]: got %h expected %h", b, grant, 8'h04); end
            tick();
        end
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL single_release: got %h expected %h", grant, 8'h00); end
        n_checks++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL idle_beat_ready: got %b expected 0", beat_ready); end
        n_checks++; if (dut.r_credit[1] !== 4'd5) begin n_fail++; $display("FAIL single_credit1: got %0d expected 5", dut.r_credit[1]); end
        clear_inputs();
        tick();
    endtask

    task automatic test_priority;
        request[0][0] = 1'b1;
        request[5][4] = 1'b1;
        tick();
        n_checks++; if (grant !== 8'h20) begin n_fail++; $display("FAIL prio_grant: got %h expected %h", grant, 8'h20); end
        n_checks++; if (grant_vc !== flat_vc(1, 1)) begin n_fail++; $display("FAIL prio_grant_vc: got %0d expected 4", grant_vc); end
        request    = '0;
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        out_ready  = 1'b1;
        tick();
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL prio_release: got %h expected %h", grant, 8'h00); end
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin;
        int exp_in [4] = '{1, 3, 6, 1};
        apply_reset();
        request[1][2] = 1'b1;
        request[3][2] = 1'b1;
        request[6][2] = 1'b1;
        beat_valid    = 1'b1;
        beat_last     = 1'b1;
        out_ready     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (grant !== 8'(1 << exp_in[k])) begin n_fail++; $display("FAIL rr_grant[%0d]: got %h expected %h", k, grant, 8'(1 << exp_in[k])); end
            n_checks++; if (grant_vc !== flat_vc(0, 2)) begin n_fail++; $display("FAIL rr_grant_vc[%0d]: got %0d expected 2", k, grant_vc); end
            tick();
            n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL rr_gap[%0d]: got %h expected %h", k, grant, 8'h00); end
            n_checks++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL rr_gap_ready[%0d]: got %b expected 0", k, beat_ready); end
        end
        clear_inputs();
    endtask

    task automatic test_credit_stall;
        apply_reset();
        request[4][0] = 1'b1;
        tick();
        n_checks++; if (grant !== 8'h10) begin n_fail++; $display("FAIL stall_grant: got %h expected %h", grant, 8'h10); end
        request    = '0;
        beat_valid = 1'b1;
        beat_last  = 1'b0;
        out_ready  = 1'b1;
        repeat (8) tick();
        n_checks++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_empty: got %b expected 0", beat_ready); end
        n_checks++; if (grant !== 8'h10) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", grant, 8'h10); end
        credit_return[0] = 1'b1;
        tick();
        credit_return = '0;
        #1;
        n_checks++; if (beat_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_one: got %b expected 1", beat_ready); end
        tick();
        n_checks++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_again: got %b expected 0", beat_ready); end
        n_checks++; if (dut.r_credit[0] !== 4'd0) begin n_fail++; $display("FAIL stall_credit0: got %0d expected 0", dut.r_credit[0]); end
    endtask

    // Runs while test_credit_stall's packet is still open, so the reset lands mid-packet.
    task automatic test_overflow_reset;
        credit_return[3] = 1'b1;
        tick();
        credit_return = '0;
        n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", credit_err); end
        n_checks++; if (dut.r_credit[3] !== 4'd8) begin n_fail++; $display("FAIL ovf_credit3: got %0d expected 8", dut.r_credit[3]); end
        n_checks++; if (grant !== 8'h10) begin n_fail++; $display("FAIL ovf_midpkt_grant: got %h expected %h", grant, 8'h10); end
        resetn = 1'b0;
        #1;
        n_checks++; if (grant !== 8'h00) begin n_fail++; $display("FAIL async_reset_grant: got %h expected %h", grant, 8'h00); end
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL async_reset_err: got %b expected 0", credit_err); end
        n_checks++; if (dut.r_credit[0] !== 4'd8) begin n_fail++; $display("FAIL async_reset_credit0: got %0d expected 8", dut.r_credit[0]); end
        n_checks++; if (o_dbg_state !== 1'b0) begin n_fail++; $display("FAIL async_reset_state: got %b expected 0", o_dbg_state); end
        clear_inputs();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        resetn = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_credit_stall();
        test_overflow_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
